// File: rtl/spmul_pkg.sv
// Shared widths, FSM encoding and sign helper for the serial/parallel coefficient multiplier.
package spmul_pkg;

  localparam int SIG_W          = 16;
  localparam int COEF_W         = 10;
  localparam int COEF_FRAC_BITS = 9;
  localparam int ACC_W          = SIG_W + 1;
  localparam int STEP_COUNT     = 9;
  localparam int CNT_W          = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } spmul_state_e;

  // Control snapshot kept as one named signal so checkers can bind to it.
  typedef struct packed {
    spmul_state_e     state;
    logic [CNT_W-1:0] cnt;
  } spmul_dbg_t;

  // Apply the coefficient sign to a floored magnitude product; the value always fits SIG_W.
  function automatic logic [SIG_W-1:0] apply_sign(input logic neg,
                                                  input logic signed [ACC_W-1:0] val);
    return SIG_W'(neg ? -val : val);
  endfunction

endpackage

// File: rtl/spmul.sv
// Serial/parallel multiplier: 16-bit signed sample times 10-bit sign-magnitude Q0.9 coefficient,
// one magnitude bit per clock, LSB first, result floored before the sign is applied.
module spmul
  import spmul_pkg::*;
(
  input  logic        clk,
  input  logic        rst_an,
  input  logic [15:0] sig_in,
  input  logic [9:0]  coef_in,
  input  logic        start,
  output logic [15:0] result_out,
  output logic        done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEP_COUNT - 1);

  // Handshake: start is sampled on every rising edge and always wins (restart while busy).
  // done=1 means idle with result_out valid; done=0 means a multiply is in flight.

  spmul_state_e                state_q;
  spmul_state_e                state_d;
  spmul_dbg_t                  dbg;
  logic [CNT_W-1:0]            cnt_q;
  logic [SIG_W-1:0]            sig_q;
  logic [COEF_FRAC_BITS-1:0]   mag_q;
  logic                        sign_q;
  logic signed [ACC_W-1:0]     acc_q;
  logic signed [ACC_W-1:0]     addend;
  logic signed [ACC_W-1:0]     acc_sum;
  logic signed [ACC_W-1:0]     acc_next;
  logic [SIG_W-1:0]            result_q;
  logic                        last_step;

  assign dbg       = '{state: state_q, cnt: cnt_q};
  assign last_step = (state_q == ST_RUN) && (cnt_q == LAST_CNT);

  // Shift-right after every add keeps acc equal to floor(partial / 2^(k+1)).
  assign addend   = mag_q[0] ? {{(ACC_W - SIG_W){sig_q[SIG_W-1]}}, sig_q} : '0;
  assign acc_sum  = acc_q + addend;
  assign acc_next = acc_sum >>> 1;

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_RUN;
    end else if (last_step) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      sig_q    <= '0;
      mag_q    <= '0;
      sign_q   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      // A completing multiply still publishes its result even if a restart arrives on the same edge.
      if (last_step) begin
        result_q <= apply_sign(sign_q, acc_next);
      end
      if (start) begin
        sig_q  <= sig_in;
        mag_q  <= coef_in[COEF_FRAC_BITS-1:0];
        sign_q <= coef_in[COEF_W-1];
        acc_q  <= '0;
        cnt_q  <= '0;
      end else if (state_q == ST_RUN) begin
        acc_q <= acc_next;
        mag_q <= mag_q >> 1;
        cnt_q <= last_step ? '0 : cnt_q + CNT_W'(1);
      end
    end
  end

  assign result_out = result_q;
  assign done       = (dbg.state == ST_IDLE);

endmodule

// File: tb/tb_spmul.sv
// Self-checking bench for spmul: directed vectors, handshake timing, restart, async reset, random sweep.
module tb_spmul;

  logic        clk;
  logic        rst_an;
  logic [15:0] sig_in;
  logic [9:0]  coef_in;
  logic        start;
  logic [15:0] result_out;
  logic        done;

  int checks;
  int failures;
  logic [15:0] exp_q[$];

  spmul dut (
    .clk        (clk),
    .rst_an     (rst_an),
    .sig_in     (sig_in),
    .coef_in    (coef_in),
    .start      (start),
    .result_out (result_out),
    .done       (done)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: floor(sig*m/512) by integer division, then apply sign.
  function automatic logic [15:0] ref_mul(input logic [15:0] sig, input logic [9:0] coef);
    int s;
    int m;
    int p;
    int q;
    s = int'($signed(sig));
    m = int'(coef[8:0]);
    p = s * m;
    if (p >= 0) q = p / 512;
    else        q = -((-p + 511) / 512);
    if (coef[9]) q = -q;
    return 16'(q);
  endfunction

  // driver tasks; all driving happens just after a falling edge
  task automatic drive_start(input logic [15:0] s, input logic [9:0] c);
    sig_in  = s;
    coef_in = c;
    start   = 1'b1;
  endtask

  // Counts falling edges until done is seen high; 0 means the bound expired.
  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        cycles = c;
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst_an  = 1'b0;
    start   = 1'b0;
    sig_in  = '0;
    coef_in = '0;
    #3;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL reset_done got=%b exp=1", done);
    end
    checks++;
    if (result_out !== 16'd0) begin
      failures++;
      $display("FAIL reset_result got=%0d exp=0", $signed(result_out));
    end
    @(negedge clk);
    @(negedge clk);
    rst_an = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [15:0] sigs[7];
    logic [9:0]  coefs[7];
    logic [15:0] exps[7];
    int cyc;
    sigs  = '{16'd1000, 16'd100, 16'h8000, 16'h8000, 16'hFFFD, 16'hFFFD, 16'd12345};
    coefs = '{10'h100, 10'h300, 10'h1FF, 10'h3FF, 10'h001, 10'h201, 10'h200};
    exps  = '{16'd500, 16'hFFCE, 16'h8040, 16'd32704, 16'hFFFF, 16'd1, 16'd0};
    for (int i = 0; i < 7; i++) begin
      drive_start(sigs[i], coefs[i]);
      wait_done(cyc);
      checks++;
      if (cyc != 10) begin
        failures++;
        $display("FAIL directed_latency vec=%0d got=%0d exp=10", i, cyc);
      end
      checks++;
      if (result_out !== exps[i]) begin
        failures++;
        $display("FAIL directed_result vec=%0d got=%0d exp=%0d", i, $signed(result_out), $signed(exps[i]));
      end
    end
  endtask

  task automatic test_handshake;
    logic [15:0] prev;
    logic [15:0] s;
    logic [9:0]  c;
    prev = result_out;
    s = 16'(-1234);
    c = 10'h155;
    drive_start(s, c);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL hs_busy cycle=%0d got=%b exp=0", k, done);
      end
      checks++;
      if (result_out !== prev) begin
        failures++;
        $display("FAIL hs_hold cycle=%0d got=%0d exp=%0d", k, $signed(result_out), $signed(prev));
      end
      sig_in  = 16'($urandom);
      coef_in = 10'($urandom);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL hs_done got=%b exp=1", done);
    end
    checks++;
    if (result_out !== ref_mul(s, c)) begin
      failures++;
      $display("FAIL hs_result got=%0d exp=%0d", $signed(result_out), $signed(ref_mul(s, c)));
    end
  endtask

  task automatic test_restart;
    logic [15:0] prev;
    int cyc;
    prev = result_out;
    drive_start(16'd20000, 10'h1F0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    drive_start(16'd7000, 10'h0C8);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (result_out !== prev) begin
      failures++;
      $display("FAIL restart_no_first got=%0d exp=%0d", $signed(result_out), $signed(prev));
    end
    wait_done(cyc);
    checks++;
    if (cyc != 9) begin
      failures++;
      $display("FAIL restart_latency got=%0d exp=9", cyc);
    end
    checks++;
    if (result_out !== ref_mul(16'd7000, 10'h0C8)) begin
      failures++;
      $display("FAIL restart_result got=%0d exp=%0d", $signed(result_out),
               $signed(ref_mul(16'd7000, 10'h0C8)));
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    drive_start(16'(-5000), 10'h2AB);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    drive_start(16'd3210, 10'h07F);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done_low got=%b exp=0", done);
    end
    checks++;
    if (result_out !== ref_mul(16'(-5000), 10'h2AB)) begin
      failures++;
      $display("FAIL b2b_first got=%0d exp=%0d", $signed(result_out),
               $signed(ref_mul(16'(-5000), 10'h2AB)));
    end
    wait_done(cyc);
    checks++;
    if (cyc != 9) begin
      failures++;
      $display("FAIL b2b_latency got=%0d exp=9", cyc);
    end
    checks++;
    if (result_out !== ref_mul(16'd3210, 10'h07F)) begin
      failures++;
      $display("FAIL b2b_second got=%0d exp=%0d", $signed(result_out),
               $signed(ref_mul(16'd3210, 10'h07F)));
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    drive_start(16'd9999, 10'h1AA);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_an = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL midreset_done got=%b exp=1", done);
    end
    checks++;
    if (result_out !== 16'd0) begin
      failures++;
      $display("FAIL midreset_result got=%0d exp=0", $signed(result_out));
    end
    @(negedge clk);
    rst_an = 1'b1;
    @(negedge clk);
    drive_start(16'(-32768), 10'h3FF);
    wait_done(cyc);
    checks++;
    if (cyc != 10 || result_out !== 16'd32704) begin
      failures++;
      $display("FAIL postreset_mul cyc=%0d got=%0d exp=32704 in 10", cyc, $signed(result_out));
    end
  endtask

  task automatic test_random;
    logic [15:0] s;
    logic [9:0]  c;
    logic [15:0] exp_v;
    int cyc;
    for (int i = 0; i < 3000; i++) begin
      s = 16'($urandom);
      c = 10'($urandom);
      case ($urandom_range(0, 9))
        0: c[8:0] = 9'd0;
        1: c[8:0] = 9'h1FF;
        2: s = 16'h8000;
        3: s = 16'h7FFF;
        default: ;
      endcase
      exp_q.push_back(ref_mul(s, c));
      drive_start(s, c);
      wait_done(cyc);
      exp_v = exp_q.pop_front();
      checks++;
      if (cyc != 10 || result_out !== exp_v) begin
        failures++;
        $display("FAIL random i=%0d sig=%0d coef=%h cyc=%0d got=%0d exp=%0d", i, $signed(s), c, cyc,
                 $signed(result_out), $signed(exp_v));
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset;
    test_directed;
    test_handshake;
    test_restart;
    test_back_to_back;
    test_reset_mid;
    test_random;
    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
